// File: rtl/conv_pkg.sv
// Shared types, default widths and the output saturation/ReLU helper for the
// streaming convolution engine.
package conv_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int KERNEL_SIZE_DEF = 5;
    localparam int TAPS_DEF        = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF;
    localparam int TAPS_CLOG2_DEF  = $clog2(TAPS_DEF);
    localparam int ACC_WIDTH_DEF   = 2 * DATA_WIDTH_DEF + TAPS_CLOG2_DEF + 1;
    localparam int WIDE_W          = 128;

    typedef logic signed [DATA_WIDTH_DEF-1:0]   pixel_t;
    typedef logic signed [2*DATA_WIDTH_DEF-1:0] prod_t;
    typedef logic signed [ACC_WIDTH_DEF-1:0]    acc_t;
    typedef logic signed [WIDE_W-1:0]           wide_t;

    // Clamp to the signed out_width range, optionally forcing negatives to zero.
    function automatic wide_t sat_relu(input wide_t val, input int out_width, input logic relu);
        wide_t hi;
        wide_t lo;
        wide_t res;
        hi = (wide_t'(1) <<< (out_width - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (relu && (val < wide_t'(0))) begin
            res = '0;
        end else if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered signed reduction of N packed operands, advancing only when enabled.
module conv_adder_tree #(
    parameter int N     = 25,
    parameter int IN_W  = 32,
    parameter int OUT_W = 38
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [N*IN_W-1:0]       in_flat_i,
    output logic signed [OUT_W-1:0] sum_o
);

    logic signed [OUT_W-1:0] sum_d;

    // Sign-extend every operand to the accumulator width and add them up.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d = sum_d + OUT_W'($signed(in_flat_i[i*IN_W +: IN_W]));
        end
    end

    // Output register; holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_o <= '0;
        end else if (en_i) begin
            sum_o <= sum_d;
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KxK signed convolution: column-fed sliding window, three-stage
// multiply / add-tree / bias-shift-saturate pipeline with valid/ready flow.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int OUT_WIDTH   = 32,
    parameter int BIAS_WIDTH  = 32,
    parameter int SHIFT       = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] col_in,
    input  logic                              col_valid,
    output logic                              col_ready,
    input  logic                              row_start,
    input  logic                              kernel_valid,
    input  logic [BIAS_WIDTH-1:0]             bias_in,
    input  logic                              relu_en,
    output logic signed [OUT_WIDTH-1:0]       out_data,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int K         = KERNEL_SIZE;
    localparam int TAPS      = K * K;
    localparam int PROD_W    = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH = PROD_W + $clog2(TAPS) + 1;
    localparam int CNT_W     = $clog2(K + 1);

    logic signed [DATA_WIDTH-1:0] w_q   [K][K];
    logic signed [DATA_WIDTH-1:0] win_q [K][K];
    logic signed [DATA_WIDTH-1:0] win_d [K][K];
    logic signed [BIAS_WIDTH-1:0] bias_q;
    logic [CNT_W-1:0]             kcnt_q;
    logic [CNT_W-1:0]             fill_q;
    logic [CNT_W-1:0]             fill_d;
    logic [TAPS*PROD_W-1:0]       prod_q;
    logic [TAPS*PROD_W-1:0]       prod_d;
    logic signed [PROD_W-1:0]     prod_tmp;
    logic signed [ACC_WIDTH-1:0]  sum_q;
    logic                         v1_q;
    logic                         v2_q;
    logic                         adv;
    logic                         accept;
    logic                         kern_acc;
    logic                         img_acc;
    wide_t                        biased;
    logic signed [OUT_WIDTH-1:0]  res_d;

    assign adv       = !out_valid | out_ready;
    assign col_ready = adv & !rst;
    assign accept    = col_valid & col_ready;
    assign kern_acc  = accept & kernel_valid;
    assign img_acc   = accept & !kernel_valid;

    // Next window and fill count; the incoming column lands in the newest slot.
    always_comb begin
        fill_d = fill_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (img_acc) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_in[r*DATA_WIDTH +: DATA_WIDTH];
            end
            if (row_start) begin
                fill_d = CNT_W'(1);
            end else if (fill_q != CNT_W'(K)) begin
                fill_d = fill_q + CNT_W'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            fill_d = fill_q;
        end
    end

    // Products use the post-shift window so S1 captures the just-accepted column.
    always_comb begin
        prod_d   = '0;
        prod_tmp = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                prod_tmp = PROD_W'(w_q[r][c]) * PROD_W'(win_d[r][c]);
                prod_d[(r*K+c)*PROD_W +: PROD_W] = prod_tmp;
            end
        end
    end

    conv_adder_tree #(
        .N     (TAPS),
        .IN_W  (PROD_W),
        .OUT_W (ACC_WIDTH)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .en_i      (adv),
        .in_flat_i (prod_q),
        .sum_o     (sum_q)
    );

    // S3 arithmetic: bias add, arithmetic shift, then ReLU/saturation.
    always_comb begin
        biased = (wide_t'(sum_q) + wide_t'(bias_q)) >>> SHIFT;
        res_d  = OUT_WIDTH'(sat_relu(biased, OUT_WIDTH, relu_en));
    end

    // Kernel/window state and pipeline registers; a kernel load flushes valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    w_q[r][c]   <= '0;
                    win_q[r][c] <= '0;
                end
            end
            bias_q    <= '0;
            kcnt_q    <= '0;
            fill_q    <= '0;
            prod_q    <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (kern_acc) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        w_q[r][c] <= w_q[r][c+1];
                    end
                    w_q[r][K-1] <= col_in[r*DATA_WIDTH +: DATA_WIDTH];
                end
                if (kcnt_q == CNT_W'(K - 1)) begin
                    bias_q <= bias_in;
                    kcnt_q <= '0;
                end else begin
                    kcnt_q <= kcnt_q + CNT_W'(1);
                end
                fill_q <= '0;
            end else if (img_acc) begin
                win_q  <= win_d;
                fill_q <= fill_d;
            end
            if (adv) begin
                prod_q    <= prod_d;
                v1_q      <= img_acc && (fill_d == CNT_W'(K));
                v2_q      <= kern_acc ? 1'b0 : v1_q;
                out_valid <= kern_acc ? 1'b0 : v2_q;
                if (v2_q) begin
                    out_data <= res_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: a reference model predicts each
// output on column acceptance; results are checked as the DUT presents them.
module tb_conv_stream_engine;

    localparam int DW = 16;
    localparam int K  = 5;
    localparam int OW = 32;
    localparam int BW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [K*DW-1:0] col_in;
    logic            col_valid;
    logic            row_start;
    logic            kernel_valid;
    logic [BW-1:0]   bias_in;
    logic            relu_en;
    logic            out_ready;
    logic            col_ready;
    logic            out_valid;
    logic signed [OW-1:0] out_data;
    logic            col_ready2;
    logic            out_valid2;
    logic signed [OW-1:0] out_data2;

    always #5 clk = ~clk;

    conv_stream_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .OUT_WIDTH(OW), .BIAS_WIDTH(BW), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .col_valid(col_valid), .col_ready(col_ready),
        .row_start(row_start), .kernel_valid(kernel_valid), .bias_in(bias_in), .relu_en(relu_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

    conv_stream_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .OUT_WIDTH(OW), .BIAS_WIDTH(BW), .SHIFT(2)) dut_sh2 (
        .clk(clk), .rst(rst), .col_in(col_in), .col_valid(col_valid), .col_ready(col_ready2),
        .row_start(row_start), .kernel_valid(kernel_valid), .bias_in(bias_in), .relu_en(relu_en),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready));

    typedef struct {
        longint v;
        bit     relu;
        int     t;
        bit     seen;
    } exp_t;

    exp_t   sb[$];
    longint mw[K][K];
    longint mwin[K][K];
    longint mbias;
    int     mfill;
    int     mkcnt;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    bit     lat_mode = 1'b1;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint model_out(input longint v, input bit relu, input int sh);
        longint r;
        r = v >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 64'sd2147483647) r = 64'sd2147483647;
        else if (r < -64'sd2147483648) r = -64'sd2147483648;
        return r;
    endfunction

    // mode 0 uniform v, 1 ramp, 2 random, 3 identity-kernel column idx
    function automatic logic [K*DW-1:0] mkcol(input int mode, input longint v, input int idx);
        logic [K*DW-1:0] c;
        logic [DW-1:0]   p;
        c = '0;
        for (int r = 0; r < K; r++) begin
            case (mode)
                0:       p = DW'(v);
                1:       p = DW'(10 * idx + r);
                2:       p = DW'($urandom_range(0, 400)) - 16'd200;
                default: p = (r == K / 2 && idx == K / 2) ? 16'd1 : 16'd0;
            endcase
            c[r*DW +: DW] = p;
        end
        return c;
    endfunction

    // Reference model: follows every accepted column at the clock edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) begin
                    mw[r][c] = 0;
                    mwin[r][c] = 0;
                end
            mbias = 0; mfill = 0; mkcnt = 0;
            sb.delete();
        end else if (col_valid && col_ready) begin
            if (kernel_valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) mw[r][c] = mw[r][c+1];
                    mw[r][K-1] = longint'($signed(col_in[r*DW +: DW]));
                end
                if (mkcnt == K - 1) begin
                    mbias = longint'($signed(bias_in));
                    mkcnt = 0;
                end else begin
                    mkcnt++;
                end
                mfill = 0;
                sb.delete();
            end else begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) mwin[r][c] = mwin[r][c+1];
                    mwin[r][K-1] = longint'($signed(col_in[r*DW +: DW]));
                end
                if (row_start) mfill = 1;
                else if (mfill < K) mfill++;
                if (mfill == K) begin
                    longint s;
                    s = mbias;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++) s += mw[r][c] * mwin[r][c];
                    sb.push_back('{v: s, relu: relu_en, t: cyc, seen: 1'b0});
                end
            end
        end
        cyc++;
    end

    // Output checker: compares the presented result with the scoreboard head.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check_val("col_ready", col_ready, longint'(!(out_valid && !out_ready)));
            check_val("valid_sh2", out_valid2, out_valid);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_valid", out_valid, 0);
                end else begin
                    check_val("data", out_data, model_out(sb[0].v, sb[0].relu, 0));
                    check_val("data_sh2", out_data2, model_out(sb[0].v, sb[0].relu, 2));
                    if (lat_mode && !sb[0].seen) check_val("latency", cyc - sb[0].t, 3);
                    sb[0].seen = 1'b1;
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [K*DW-1:0] col, input bit kern, input bit rs);
        int  waitc;
        bit  took;
        waitc = 0;
        took  = 1'b0;
        col_in = col; col_valid = 1'b1; kernel_valid = kern; row_start = rs;
        while (!took && waitc < 100) begin
            @(negedge clk);
            took = col_ready;
            tick();
            waitc++;
        end
        if (!took) check_val("send_timeout", took, 1);
        col_valid = 1'b0; kernel_valid = 1'b0; row_start = 1'b0;
    endtask

    task automatic load_kernel(input int mode, input longint v, input longint b);
        bias_in = BW'(b);
        for (int i = 0; i < K; i++) send(mkcol(mode, v, i), 1'b1, 1'b0);
    endtask

    task automatic stream(input int n, input int mode, input longint v, input bit rs_first, input int idx0);
        for (int i = 0; i < n; i++) send(mkcol(mode, v, idx0 + i), 1'b0, rs_first && (i == 0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check_val("drain", sb.size(), 0);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; col_in = '0; col_valid = 1'b0; row_start = 1'b0; kernel_valid = 1'b0;
        bias_in = '0; relu_en = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check_val("rst_col_ready", col_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        tick();
        rst = 1'b0;

        // all-ones kernel and image
        load_kernel(0, 1, 0);
        stream(8, 0, 1, 1'b1, 0);
        drain();

        // identity kernel over a ramp, with a row restart
        load_kernel(3, 0, 0);
        stream(7, 1, 0, 1'b1, 0);
        stream(6, 1, 0, 1'b1, 20);
        drain();

        // positive and negative saturation
        load_kernel(0, 32767, 0);
        stream(5, 0, 32767, 1'b1, 0);
        drain();
        load_kernel(0, -32768, 0);
        stream(5, 0, 32767, 1'b1, 0);
        drain();

        // ReLU, negative result, bias with shift
        load_kernel(0, -1, 0);
        relu_en = 1'b1;
        stream(5, 0, 3, 1'b1, 0);
        drain();
        relu_en = 1'b0;
        stream(5, 0, 3, 1'b1, 0);
        drain();
        load_kernel(0, -1, 100);
        stream(5, 0, 3, 1'b1, 0);
        drain();

        // backpressure for 6 cycles mid-stream
        load_kernel(2, 0, $urandom_range(0, 2000) - 1000);
        lat_mode = 1'b0;
        fork
            begin
                repeat (7) tick();
                out_ready = 1'b0;
                repeat (6) tick();
                out_ready = 1'b1;
            end
        join_none
        stream(14, 2, 0, 1'b1, 0);
        drain();
        lat_mode = 1'b1;

        // reset with results in flight
        stream(6, 2, 0, 1'b1, 0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_val("rst_flush_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();

        // kernel reload mid-row discards in-flight results and restarts fill
        load_kernel(0, 2, 0);
        stream(6, 2, 0, 1'b1, 0);
        load_kernel(2, 0, 7);
        stream(5, 2, 0, 1'b0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
